// File: rtl/pipe_defs.sv
// Shared definitions for the IF stage: next-PC select codes, fetch FSM states and the IF/ID payload.
package pipe_defs;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};

  // Same encodings the decode unit drives on pcsource.
  localparam logic [1:0] PCS_SEQ = 2'b00;
  localparam logic [1:0] PCS_BR  = 2'b01;
  localparam logic [1:0] PCS_JR  = 2'b10;
  localparam logic [1:0] PCS_J   = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_REQ  = 2'b01,
    S_HOLD = 2'b10
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] pc4;
  } ifid_t;

endpackage

// File: rtl/pipe_fetch_hold.sv
// One-entry skid register that parks a fetched word while ID is stalled.
module pipe_fetch_hold
  import pipe_defs::*;
(
  input  logic  clock,
  input  logic  reset,
  input  logic  fill,
  input  logic  drain,
  input  ifid_t fill_data,
  output ifid_t data,
  output logic  valid
);

  // Fill wins over drain; the fetch FSM never asks for both at once.
  always_ff @(posedge clock) begin
    if (reset) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (fill) begin
      valid <= 1'b1;
      data  <= fill_data;
    end else if (drain) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/pipe_fetch_unit.sv
// IF stage: owns the PC, fetches over a req/ack instruction port and fills the IF/ID register.
// One branch delay slot: a redirect from ID applies to the fetch after the delay slot.
module pipe_fetch_unit
  import pipe_defs::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            nostall,
  input  logic [1:0]      pcsource,
  input  logic [XLEN-1:0] bpc,
  input  logic [XLEN-1:0] rpc,
  input  logic [XLEN-1:0] jpc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] dinst,
  output logic [XLEN-1:0] dpc4,
  output logic            dvalid,
  output logic            fetch_busy
);

  fetch_state_e    state;
  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] redir_tgt;
  logic            redir_pend;

  ifid_t           hold_data;
  logic            hold_valid;

  logic            ack_c;
  logic            load_c;
  logic            consume_c;
  logic            fill_c;
  logic            drain_c;
  logic [XLEN-1:0] pc4_c;
  logic [XLEN-1:0] target_c;
  ifid_t           fill_data_c;

  // Handshake qualifiers, IF/ID load rule and redirect target select.
  always_comb begin
    ack_c       = (state == S_REQ) && imem_ack;
    load_c      = !dvalid || nostall;
    consume_c   = dvalid && nostall && (pcsource != PCS_SEQ);
    pc4_c       = fetch_pc + XLEN'(4);
    fill_c      = !load_c && ack_c;
    drain_c     = load_c && hold_valid;
    target_c    = bpc;
    case (pcsource)
      PCS_JR:  target_c = rpc;
      PCS_J:   target_c = jpc;
      default: target_c = bpc;
    endcase
    target_c    = target_c & ALIGN_MASK;
    fill_data_c.inst = imem_rdata;
    fill_data_c.pc4  = pc4_c;
  end

  pipe_fetch_hold u_hold (
    .clock     (clock),
    .reset     (reset),
    .fill      (fill_c),
    .drain     (drain_c),
    .fill_data (fill_data_c),
    .data      (hold_data),
    .valid     (hold_valid)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= S_IDLE;
      fetch_pc   <= RESET_PC & ALIGN_MASK;
      redir_pend <= 1'b0;
      redir_tgt  <= '0;
      imem_req   <= 1'b0;
      dinst      <= '0;
      dpc4       <= '0;
      dvalid     <= 1'b0;
    end else begin
      // IF/ID: the held word has priority over a fresh ack.
      if (drain_c) begin
        dinst  <= hold_data.inst;
        dpc4   <= hold_data.pc4;
        dvalid <= 1'b1;
      end else if (load_c && ack_c) begin
        dinst  <= imem_rdata;
        dpc4   <= pc4_c;
        dvalid <= 1'b1;
      end else if (load_c) begin
        dvalid <= 1'b0;
      end

      case (state)
        S_IDLE: begin
          state    <= S_REQ;
          imem_req <= 1'b1;
          if (consume_c) begin
            redir_pend <= 1'b1;
            redir_tgt  <= target_c;
          end
        end
        S_REQ: begin
          if (ack_c) begin
            if (redir_pend) begin
              fetch_pc   <= redir_tgt;
              redir_pend <= 1'b0;
            end else if (consume_c) begin
              fetch_pc <= target_c;
            end else begin
              fetch_pc <= pc4_c;
            end
            if (fill_c) begin
              state    <= S_HOLD;
              imem_req <= 1'b0;
            end
          end else if (consume_c) begin
            // Delay slot still in flight: apply the target on its ack.
            redir_pend <= 1'b1;
            redir_tgt  <= target_c;
          end
        end
        S_HOLD: begin
          if (consume_c) begin
            fetch_pc <= target_c;
          end
          if (drain_c) begin
            state    <= S_REQ;
            imem_req <= 1'b1;
          end
        end
        default: begin
          state    <= S_IDLE;
          imem_req <= 1'b0;
        end
      endcase
    end
  end

  assign imem_addr  = fetch_pc & ALIGN_MASK;
  assign fetch_busy = imem_req;

endmodule

// File: tb/tb_pipe_fetch_unit.sv
// Scoreboard bench for pipe_fetch_unit: a variable-latency memory model, a static program with
// branches/jumps, ID-side stalls, PC wrap-around and a reset in the middle of a request.
module tb_pipe_fetch_unit;
  import pipe_defs::*;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        nostall = 1'b1;
  logic [1:0]  pcsource = PCS_SEQ;
  logic [31:0] bpc = 32'h0;
  logic [31:0] rpc = 32'h0;
  logic [31:0] jpc = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic [31:0] dinst;
  logic [31:0] dpc4;
  logic        dvalid;
  logic        fetch_busy;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc4;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          cycles = 0;
  int          wcnt = 0;
  int          stall_left = 0;
  int          post_acks = 0;
  logic        prev_req = 1'b0;
  logic        prev_ack = 1'b0;
  logic        stall1_done = 1'b0;
  logic        stall2_done = 1'b0;
  logic        wrapped = 1'b0;
  logic        fired = 1'b0;
  logic [31:0] exp_next = 32'h0;
  logic [31:0] cur_addr = 32'h0;
  logic [31:0] stall_dpc4 = 32'h0;

  pipe_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clock      (clock),
    .reset      (reset),
    .nostall    (nostall),
    .pcsource   (pcsource),
    .bpc        (bpc),
    .rpc        (rpc),
    .jpc        (jpc),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .dinst      (dinst),
    .dpc4       (dpc4),
    .dvalid     (dvalid),
    .fetch_busy (fetch_busy)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cycles);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h2400_0000 ^ a;
  endfunction

  function automatic int lat_of(input logic [31:0] a);
    return (a >= 32'h10 && a < 32'h30) ? 3 : 1;
  endfunction

  function automatic logic [1:0] br_kind(input logic [31:0] pc);
    case (pc)
      32'h0000_0020: return PCS_BR;
      32'h0000_010C: return PCS_JR;
      32'h0000_1008: return PCS_JR;
      32'h0000_2008: return PCS_J;
      default:       return PCS_SEQ;
    endcase
  endfunction

  function automatic logic [31:0] br_raw(input logic [31:0] pc);
    case (pc)
      32'h0000_0020: return 32'h0000_0100;
      32'h0000_010C: return 32'h0000_1003;
      32'h0000_1008: return 32'h0000_2003;
      32'h0000_2008: return 32'hFFFF_FFFA;
      default:       return 32'h0;
    endcase
  endfunction

  // Fetch that must follow address a: the delay slot of a branch at a-4 redirects.
  function automatic logic [31:0] next_addr(input logic [31:0] a);
    logic [31:0] pc;
    pc = a - 32'd4;
    if (br_kind(pc) != PCS_SEQ) return br_raw(pc) & 32'hFFFF_FFFC;
    return a + 32'd4;
  endfunction

  task automatic tb_cycle();
    logic        ack;
    logic        req_start;
    logic [31:0] pc;
    exp_t        e;
    @(posedge clock);
    #1;
    cycles++;
    if (prev_req && !prev_ack) begin
      check("req_stable", 32'(imem_req), 32'd1);
      check("addr_stable", imem_addr, cur_addr);
    end
    req_start = imem_req && (!prev_req || prev_ack);
    if (req_start) begin
      check("fetch_addr", imem_addr, exp_next);
      cur_addr = exp_next;
      wcnt = 0;
    end else if (imem_req) begin
      wcnt++;
    end

    if (dvalid && stall_left == 0) begin
      if (!stall1_done && dpc4 == 32'h0000_000C) begin
        stall1_done = 1'b1;
        stall_left  = 5;
        stall_dpc4  = 32'h0000_000C;
      end else if (!stall2_done && dpc4 == 32'h0000_0110) begin
        stall2_done = 1'b1;
        stall_left  = 4;
        stall_dpc4  = 32'h0000_0110;
      end
    end
    nostall = (stall_left == 0);

    pc = dpc4 - 32'd4;
    bpc = 32'h5555_5550;
    rpc = 32'hAAAA_AAA0;
    jpc = 32'h3333_3330;
    pcsource = PCS_SEQ;
    if (dvalid) begin
      pcsource = br_kind(pc);
      case (pcsource)
        PCS_BR:  bpc = br_raw(pc);
        PCS_JR:  rpc = br_raw(pc);
        PCS_J:   jpc = br_raw(pc);
        default: ;
      endcase
    end

    if (stall_left > 0) begin
      stall_left--;
      if (stall_left == 0) begin
        check("stall_req_drop", 32'(imem_req), 32'd0);
        check("stall_busy", 32'(fetch_busy), 32'd0);
        check("stall_dpc4_hold", dpc4, stall_dpc4);
      end
    end

    if (dvalid && nostall) begin
      if (sb.size() == 0) begin
        check("sb_underflow", 32'(dvalid), 32'd0);
      end else begin
        e = sb.pop_front();
        check("dinst", dinst, e.inst);
        check("dpc4", dpc4, e.pc4);
      end
    end

    ack = imem_req && (wcnt == lat_of(cur_addr) - 1);
    if (wrapped && !fired && imem_req && cur_addr == 32'h0000_0010 && wcnt == 1) begin
      fired = 1'b1;
      reset = 1'b1;
      ack   = 1'b0;
    end
    imem_ack   = ack;
    imem_rdata = ack ? mem_word(imem_addr) : 32'hDEAD_BEEF;
    if (ack) begin
      sb.push_back({mem_word(cur_addr), cur_addr + 32'd4});
      exp_next = next_addr(cur_addr);
      if (cur_addr == 32'hFFFF_FFFC) wrapped = 1'b1;
      post_acks++;
    end
    prev_req = imem_req;
    prev_ack = ack;
  endtask

  initial begin
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_busy", 32'(fetch_busy), 32'd0);
    check("rst_dvalid", 32'(dvalid), 32'd0);
    check("rst_dinst", dinst, 32'd0);
    check("rst_dpc4", dpc4, 32'd0);
    check("rst_addr", imem_addr, 32'h0000_0000);
    reset = 1'b0;

    while (!fired && cycles < 4000) tb_cycle();

    if (!fired) begin
      check("reset_point_reached", 32'(fired), 32'd1);
    end else begin
      @(posedge clock);
      #1;
      check("midreq_rst_req", 32'(imem_req), 32'd0);
      check("midreq_rst_busy", 32'(fetch_busy), 32'd0);
      check("midreq_rst_dvalid", 32'(dvalid), 32'd0);
      reset      = 1'b0;
      imem_ack   = 1'b1;
      imem_rdata = 32'hBAD0_BAD0;
      nostall    = 1'b1;
      pcsource   = PCS_SEQ;
      sb.delete();
      prev_req   = 1'b0;
      prev_ack   = 1'b0;
      exp_next   = 32'h0000_0000;
      wcnt       = 0;
      post_acks  = 0;
      repeat (24) tb_cycle();
      check("post_rst_progress", 32'(post_acks >= 8), 32'd1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
